wb_ram_arbiter: RTL and testbench

Two-master, one-slave Wishbone classic arbiter that shares the single on-chip RAM port between the CPU instruction bus (`inst_*`) and data bus (`data_*`). It sits between the core and `wb_ram`. It drives the `ram_*` bus from whichever master holds the grant and returns `ack` only to that master. The grant is locked for the whole of a master's `cyc`, so bursts and read-modify-write sequences are never interleaved.

---
 rtl/wb_ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_arbiter
// Purpose  : Two-master, one-slave Wishbone classic arbiter. Shares the single
//            on-chip RAM port between the CPU instruction bus (inst_*) and the
//            data bus (data_*). The grant is held for the whole of the owning
//            master's cyc, so bursts and read-modify-write sequences are never
//            interleaved with the other master's accesses.
// Ports    : clk_i                 system clock, rising edge
//            rst_ni                synchronous active-low reset
//            inst_*_i / inst_*_o   instruction master request / rdata, ack
//            data_*_i / data_*_o   data master request / rdata, ack
//            ram_*_o / ram_*_i     slave request / rdata, ack
//            gnt_o                 registered one-hot grant (bit0 inst, bit1 data)
// Options  : ARB_RR_EN defined   -> round-robin on a tie (first tie goes to data)
//            ARB_RR_EN undefined -> fixed priority, data wins a tie
// Revision : 1.0  initial release
// ============================================================================
module wb_ram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // instruction master
    input  logic [AW-1:0]   inst_addr_i,
    input  logic [DW-1:0]   inst_wdata_i,
    input  logic [DW/8-1:0] inst_sel_i,
    input  logic            inst_we_i,
    input  logic            inst_cyc_i,
    input  logic            inst_stb_i,
    output logic [DW-1:0]   inst_rdata_o,
    output logic            inst_ack_o,
    // data master
    input  logic [AW-1:0]   data_addr_i,
    input  logic [DW-1:0]   data_wdata_i,
    input  logic [DW/8-1:0] data_sel_i,
    input  logic            data_we_i,
    input  logic            data_cyc_i,
    input  logic            data_stb_i,
    output logic [DW-1:0]   data_rdata_o,
    output logic            data_ack_o,
    // RAM slave
    output logic [AW-1:0]   ram_addr_o,
    output logic [DW-1:0]   ram_wdata_o,
    output logic [DW/8-1:0] ram_sel_o,
    output logic            ram_we_o,
    output logic            ram_cyc_o,
    output logic            ram_stb_o,
    input  logic [DW-1:0]   ram_rdata_i,
    input  logic            ram_ack_i,
    // grant
    output logic [1:0]      gnt_o
);

    // State codes double as the one-hot grant vector, so gnt_o is simply the
    // state register.
    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_GNT_I = 2'b01;
    localparam logic [1:0] c_GNT_D = 2'b10;

    logic [1:0] state_q, state_d;
    logic       tie_to_data;

`ifdef ARB_RR_EN
    // Most recently granted master: 0 = inst, 1 = data.
    logic last_q, last_d;

    // A tie goes to whichever master was not served last.
    assign tie_to_data = ~last_q;

    always_comb begin
        last_d = last_q;
        if (state_q == c_IDLE && state_d != c_IDLE) begin
            last_d = (state_d == c_GNT_D);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign tie_to_data = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (inst_cyc_i && data_cyc_i) begin
                    state_d = tie_to_data ? c_GNT_D : c_GNT_I;
                end else if (data_cyc_i) begin
                    state_d = c_GNT_D;
                end else if (inst_cyc_i) begin
                    state_d = c_GNT_I;
                end
            end
            // The grant is held on cyc alone; stb may toggle freely.
            c_GNT_I: if (!inst_cyc_i) state_d = c_IDLE;
            c_GNT_D: if (!data_cyc_i) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus multiplexers, combinational from the registered state. In IDLE
    // the slave bus is driven to zero and any ram_ack is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_sel_o   = '0;
        ram_we_o    = 1'b0;
        ram_cyc_o   = 1'b0;
        ram_stb_o   = 1'b0;
        inst_ack_o  = 1'b0;
        data_ack_o  = 1'b0;
        case (state_q)
            c_GNT_I: begin
                ram_addr_o  = inst_addr_i;
                ram_wdata_o = inst_wdata_i;
                ram_sel_o   = inst_sel_i;
                ram_we_o    = inst_we_i;
                ram_cyc_o   = inst_cyc_i;
                ram_stb_o   = inst_stb_i;
                inst_ack_o  = ram_ack_i;
            end
            c_GNT_D: begin
                ram_addr_o  = data_addr_i;
                ram_wdata_o = data_wdata_i;
                ram_sel_o   = data_sel_i;
                ram_we_o    = data_we_i;
                ram_cyc_o   = data_cyc_i;
                ram_stb_o   = data_stb_i;
                data_ack_o  = ram_ack_i;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the acked master consumes it.
    assign inst_rdata_o = ram_rdata_i;
    assign data_rdata_o = ram_rdata_i;

    assign gnt_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ram_arbiter
// Purpose  : Directed self-checking bench for wb_ram_arbiter. The RAM slave
//            is emulated by driving ram_ack/ram_rdata directly. Expected tie
//            outcomes follow ARB_RR_EN when that macro is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] inst_addr, data_addr, ram_addr;
    logic [DW-1:0] inst_wdata, data_wdata, ram_wdata;
    logic [3:0]    inst_sel, data_sel, ram_sel;
    logic          inst_we, data_we, ram_we;
    logic          inst_cyc, data_cyc, ram_cyc;
    logic          inst_stb, data_stb, ram_stb;
    logic [DW-1:0] inst_rdata, data_rdata, ram_rdata;
    logic          inst_ack, data_ack, ram_ack;
    logic [1:0]    gnt;

    int n_total = 0;
    int n_bad   = 0;

    wb_ram_arbiter #(.AW(AW), .DW(DW)) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .inst_addr_i  (inst_addr),
        .inst_wdata_i (inst_wdata),
        .inst_sel_i   (inst_sel),
        .inst_we_i    (inst_we),
        .inst_cyc_i   (inst_cyc),
        .inst_stb_i   (inst_stb),
        .inst_rdata_o (inst_rdata),
        .inst_ack_o   (inst_ack),
        .data_addr_i  (data_addr),
        .data_wdata_i (data_wdata),
        .data_sel_i   (data_sel),
        .data_we_i    (data_we),
        .data_cyc_i   (data_cyc),
        .data_stb_i   (data_stb),
        .data_rdata_o (data_rdata),
        .data_ack_o   (data_ack),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_sel_o    (ram_sel),
        .ram_we_o     (ram_we),
        .ram_cyc_o    (ram_cyc),
        .ram_stb_o    (ram_stb),
        .ram_rdata_i  (ram_rdata),
        .ram_ack_i    (ram_ack),
        .gnt_o        (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single access by the expected winner of a continuous tie. The
    // winner drops cyc for one cycle after its ack, then re-requests.
    task automatic tie_access(input logic [1:0] exp, input int idx);
        tick();
        check($sformatf("tie%0d_gnt", idx), {30'd0, gnt}, {30'd0, exp});
        ram_ack   = 1'b1;
        ram_rdata = 32'hA5A5_0000 + idx;
        #1;
        check($sformatf("tie%0d_iack", idx), {31'd0, inst_ack}, {31'd0, exp[0]});
        check($sformatf("tie%0d_dack", idx), {31'd0, data_ack}, {31'd0, exp[1]});
        tick();
        ram_ack = 1'b0;
        if (exp[0]) begin inst_cyc = 1'b0; inst_stb = 1'b0; end
        if (exp[1]) begin data_cyc = 1'b0; data_stb = 1'b0; end
        tick();
        check($sformatf("tie%0d_rel", idx), {30'd0, gnt}, 32'd0);
        inst_cyc = 1'b1; inst_stb = 1'b1;
        data_cyc = 1'b1; data_stb = 1'b1;
    endtask

    initial begin
        // ---------------- reset with both masters requesting ----------------
        rst_n      = 1'b0;
        inst_addr  = 32'h0000_0200; inst_wdata = 32'h1111_1111; inst_sel = 4'hF;
        inst_we    = 1'b0; inst_cyc = 1'b1; inst_stb = 1'b1;
        data_addr  = 32'h0000_0100; data_wdata = 32'h2222_2222; data_sel = 4'hF;
        data_we    = 1'b0; data_cyc = 1'b1; data_stb = 1'b1;
        ram_rdata  = 32'h0;
        ram_ack    = 1'b1;   // stray ack during reset must not be forwarded
        repeat (3) tick();
        check("rst_gnt",  {30'd0, gnt}, 32'd0);
        check("rst_rcyc", {31'd0, ram_cyc}, 32'd0);
        check("rst_iack", {31'd0, inst_ack}, 32'd0);
        check("rst_dack", {31'd0, data_ack}, 32'd0);
        check("rst_addr", ram_addr, 32'd0);

        rst_n   = 1'b1;
        ram_ack = 1'b0;
        tick();
        check("post_rst_gnt",  {30'd0, gnt}, 32'd2);
        check("post_rst_addr", ram_addr, 32'h0000_0100);
        inst_cyc = 1'b0; inst_stb = 1'b0;
        data_cyc = 1'b0; data_stb = 1'b0;
        tick();
        check("post_rst_rel", {30'd0, gnt}, 32'd0);

        // ---------------- single instruction read at 0x40 ----------------
        inst_addr = 32'h0000_0040;
        inst_cyc  = 1'b1; inst_stb = 1'b1;
        tick();
        check("ird_gnt",  {30'd0, gnt}, 32'd1);
        check("ird_addr", ram_addr, 32'h0000_0040);
        check("ird_rcyc", {31'd0, ram_cyc}, 32'd1);
        check("ird_rwe",  {31'd0, ram_we}, 32'd0);
        check("ird_iack0", {31'd0, inst_ack}, 32'd0);
        tick();
        ram_ack   = 1'b1;
        ram_rdata = 32'hDEAD_BEEF;
        #1;
        check("ird_iack",  {31'd0, inst_ack}, 32'd1);
        check("ird_rdata", inst_rdata, 32'hDEAD_BEEF);
        check("ird_dack",  {31'd0, data_ack}, 32'd0);
        tick();
        ram_ack  = 1'b0;
        inst_cyc = 1'b0; inst_stb = 1'b0;
        tick();
        check("ird_rel",     {30'd0, gnt}, 32'd0);
        check("ird_rel_addr", ram_addr, 32'd0);

        // ---------------- continuous tie ----------------
        inst_cyc = 1'b1; inst_stb = 1'b1;
        data_cyc = 1'b1; data_stb = 1'b1;
`ifdef ARB_RR_EN
        tie_access(2'b10, 0);
        tie_access(2'b01, 1);
        tie_access(2'b10, 2);
`else
        tie_access(2'b10, 0);
        tie_access(2'b10, 1);
        tie_access(2'b10, 2);
`endif
        inst_cyc = 1'b0; inst_stb = 1'b0;
        data_cyc = 1'b0; data_stb = 1'b0;
        tick();
        check("tie_idle", {30'd0, gnt}, 32'd0);

        // ---------------- locked 4-beat data write burst ----------------
        data_addr  = 32'h0000_0300;
        data_wdata = 32'hCAFE_0000;
        data_sel   = 4'b0011;
        data_we    = 1'b1;
        data_cyc   = 1'b1; data_stb = 1'b1;
        tick();
        check("bst_gnt", {30'd0, gnt}, 32'd2);
        inst_cyc = 1'b1; inst_stb = 1'b1;   // inst now waits behind the burst
        for (int i = 0; i < 4; i++) begin
            ram_ack = 1'b1;
            #1;
            check($sformatf("bst%0d_gnt", i),   {30'd0, gnt}, 32'd2);
            check($sformatf("bst%0d_dack", i),  {31'd0, data_ack}, 32'd1);
            check($sformatf("bst%0d_iack", i),  {31'd0, inst_ack}, 32'd0);
            check($sformatf("bst%0d_wdata", i), ram_wdata, 32'hCAFE_0000 + i);
            tick();
            data_wdata = 32'hCAFE_0000 + i + 1;
        end
        check("bst_we",  {31'd0, ram_we}, 32'd1);
        check("bst_sel", {28'd0, ram_sel}, 32'h3);
        ram_ack  = 1'b0;
        data_cyc = 1'b0; data_stb = 1'b0; data_we = 1'b0;
        tick();
        check("bst_bubble", {30'd0, gnt}, 32'd0);
        tick();
        check("bst_inst_gnt", {30'd0, gnt}, 32'd1);

        // ---------------- reset in the middle of an access ----------------
        tick();
        check("mrst_pre_gnt", {30'd0, gnt}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("mrst_gnt", {30'd0, gnt}, 32'd0);
        rst_n    = 1'b1;
        inst_cyc = 1'b0; inst_stb = 1'b0;
        ram_ack  = 1'b1;
        #1;
        check("mrst_iack", {31'd0, inst_ack}, 32'd0);
        check("mrst_dack", {31'd0, data_ack}, 32'd0);
        check("mrst_rcyc", {31'd0, ram_cyc}, 32'd0);
        tick();
        ram_ack = 1'b0;
        check("mrst_idle", {30'd0, gnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
